// File: rtl/exunit_br_pipe.sv
// Pipelined branch/jump execution unit: resolves JAL/JALR/conditional branches, checks the
// prediction, and delivers tagged results through a LAT-deep stall-collapsing valid/ready pipe.
module exunit_br_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned TAG_W  = 6,
    parameter int unsigned LAT    = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              o_accessable,
    input  logic              i_is_vld,
    input  logic [TAG_W-1:0]  i_tag,
    input  logic              i_is_jal,
    input  logic              i_is_jalr,
    input  logic [2:0]        i_br_op,
    input  logic [DATA_W-1:0] i_rs1,
    input  logic [DATA_W-1:0] i_rs2,
    input  logic [PC_W-1:0]   i_pc,
    input  logic [DATA_W-1:0] i_imm,
    input  logic [PC_W-1:0]   i_pred_jmpaddr,
    input  logic              i_flush,
    input  logic              i_out_rdy,
    output logic              o_exfin,
    output logic [TAG_W-1:0]  o_exfin_tag,
    output logic [PC_W-1:0]   o_exfin_jmpaddr,
    output logic              o_exfin_jmpcond,
    output logic              o_exfin_jal_jalr,
    output logic [DATA_W-1:0] o_exfin_link,
    output logic              o_exfin_prsuc,
    output logic              o_exfin_prmiss,
    output logic [CNT_W-1:0]  o_exec_cnt,
    output logic [CNT_W-1:0]  o_miss_cnt
);

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [PC_W-1:0]   jmpaddr;
        logic              jmpcond;
        logic              jal_jalr;
        logic [DATA_W-1:0] link;
        logic              prsuc;
    } res_t;

    res_t             stage_q [LAT];
    res_t             stage_d [LAT];
    logic [LAT-1:0]   valid_q, valid_d;
    logic [LAT-1:0]   ready;
    logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    res_t            res_in;
    logic [PC_W-1:0] pc_imm, pc_4, jalr_sum, jmpaddr;
    logic            eq, lt, ltu, taken;
    logic            accept, handshake;

    // Resolution of the instruction presented this cycle.
    always_comb begin
        pc_imm   = i_pc + i_imm[PC_W-1:0];
        pc_4     = i_pc + PC_W'(4);
        jalr_sum = i_rs1[PC_W-1:0] + i_imm[PC_W-1:0];
        eq       = (i_rs1 == i_rs2);
        lt       = ($signed(i_rs1) < $signed(i_rs2));
        ltu      = (i_rs1 < i_rs2);
        case (i_br_op)
            3'b000:  taken = eq;
            3'b001:  taken = !eq;
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            3'b110:  taken = ltu;
            3'b111:  taken = !ltu;
            default: taken = 1'b0;
        endcase

        if (i_is_jal) begin
            jmpaddr = pc_imm;
        end else if (i_is_jalr) begin
            jmpaddr = {jalr_sum[PC_W-1:1], 1'b0};
        end else if (taken) begin
            jmpaddr = pc_imm;
        end else begin
            jmpaddr = pc_4;
        end

        res_in.tag      = i_tag;
        res_in.jmpaddr  = jmpaddr;
        res_in.jmpcond  = i_is_jal | i_is_jalr | taken;
        res_in.jal_jalr = i_is_jal | i_is_jalr;
        res_in.link     = DATA_W'(pc_4);
        res_in.prsuc    = (jmpaddr == i_pred_jmpaddr);
    end

    // Stage k can load when any stage at or after it is empty, or the consumer is ready.
    // Depends only on valid bits and i_out_rdy, never on i_is_vld.
    always_comb begin
        ready = '0;
        for (int k = 0; k < LAT; k++) begin
            ready[k] = i_out_rdy;
            for (int j = k; j < LAT; j++) begin
                if (!valid_q[j]) begin
                    ready[k] = 1'b1;
                end
            end
        end
    end

    assign accept    = i_is_vld && ready[0] && !i_flush;
    assign handshake = valid_q[LAT-1] && i_out_rdy;

    always_comb begin
        valid_d = valid_q;
        stage_d = stage_q;
        if (ready[0]) begin
            valid_d[0] = accept;
            if (accept) begin
                stage_d[0] = res_in;
            end
        end
        for (int k = 1; k < LAT; k++) begin
            if (ready[k]) begin
                valid_d[k] = valid_q[k-1];
                if (valid_q[k-1]) begin
                    stage_d[k] = stage_q[k-1];
                end
            end
        end
        if (i_flush) begin
            valid_d = '0;
        end
    end

    // Counters count the handshake even in a flush cycle; they saturate instead of wrapping.
    always_comb begin
        exec_cnt_d = exec_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (handshake && (exec_cnt_q != {CNT_W{1'b1}})) begin
            exec_cnt_d = exec_cnt_q + CNT_W'(1);
        end
        if (handshake && !stage_q[LAT-1].prsuc && (miss_cnt_q != {CNT_W{1'b1}})) begin
            miss_cnt_d = miss_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q    <= '0;
            exec_cnt_q <= '0;
            miss_cnt_q <= '0;
        end else begin
            valid_q    <= valid_d;
            exec_cnt_q <= exec_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        stage_q <= stage_d;
    end

    assign o_accessable     = ready[0];
    assign o_exfin          = valid_q[LAT-1];
    assign o_exfin_tag      = stage_q[LAT-1].tag;
    assign o_exfin_jmpaddr  = stage_q[LAT-1].jmpaddr;
    assign o_exfin_jmpcond  = stage_q[LAT-1].jmpcond;
    assign o_exfin_jal_jalr = stage_q[LAT-1].jal_jalr;
    assign o_exfin_link     = stage_q[LAT-1].link;
    assign o_exfin_prsuc    = valid_q[LAT-1] & stage_q[LAT-1].prsuc;
    assign o_exfin_prmiss   = valid_q[LAT-1] & !stage_q[LAT-1].prsuc;
    assign o_exec_cnt       = exec_cnt_q;
    assign o_miss_cnt       = miss_cnt_q;

endmodule

// File: tb/tb_exunit_br_pipe.sv
// Directed bench for exunit_br_pipe: resolution, latency, backpressure, flush, reset and
// counter saturation (second instance with 2-bit counters).
module tb_exunit_br_pipe;

    logic        clk;
    logic        rst_n;
    logic        is_vld, is_jal, is_jalr, flush, out_rdy;
    logic [5:0]  tag;
    logic [2:0]  br_op;
    logic [31:0] rs1, rs2, pc, imm, pred;

    logic        acc, exfin, jmpcond, jal_jalr, prsuc, prmiss;
    logic [5:0]  exfin_tag;
    logic [31:0] jmpaddr, link;
    logic [15:0] exec_cnt, miss_cnt;

    logic        acc2, exfin2, jmpcond2, jal_jalr2, prsuc2, prmiss2;
    logic [5:0]  exfin_tag2;
    logic [31:0] jmpaddr2, link2;
    logic [1:0]  exec_cnt2, miss_cnt2;

    int n_assert = 0;
    int n_fail   = 0;

    exunit_br_pipe dut (
        .clk(clk), .rst_n(rst_n), .o_accessable(acc), .i_is_vld(is_vld), .i_tag(tag),
        .i_is_jal(is_jal), .i_is_jalr(is_jalr), .i_br_op(br_op), .i_rs1(rs1), .i_rs2(rs2),
        .i_pc(pc), .i_imm(imm), .i_pred_jmpaddr(pred), .i_flush(flush), .i_out_rdy(out_rdy),
        .o_exfin(exfin), .o_exfin_tag(exfin_tag), .o_exfin_jmpaddr(jmpaddr),
        .o_exfin_jmpcond(jmpcond), .o_exfin_jal_jalr(jal_jalr), .o_exfin_link(link),
        .o_exfin_prsuc(prsuc), .o_exfin_prmiss(prmiss), .o_exec_cnt(exec_cnt),
        .o_miss_cnt(miss_cnt)
    );

    exunit_br_pipe #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .o_accessable(acc2), .i_is_vld(is_vld), .i_tag(tag),
        .i_is_jal(is_jal), .i_is_jalr(is_jalr), .i_br_op(br_op), .i_rs1(rs1), .i_rs2(rs2),
        .i_pc(pc), .i_imm(imm), .i_pred_jmpaddr(pred), .i_flush(flush), .i_out_rdy(out_rdy),
        .o_exfin(exfin2), .o_exfin_tag(exfin_tag2), .o_exfin_jmpaddr(jmpaddr2),
        .o_exfin_jmpcond(jmpcond2), .o_exfin_jal_jalr(jal_jalr2), .o_exfin_link(link2),
        .o_exfin_prsuc(prsuc2), .o_exfin_prmiss(prmiss2), .o_exec_cnt(exec_cnt2),
        .o_miss_cnt(miss_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic drive(input logic [5:0] t, input logic jal, input logic jalr,
                         input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p, input logic [31:0] im, input logic [31:0] pr);
        is_vld  = 1'b1;
        tag     = t;
        is_jal  = jal;
        is_jalr = jalr;
        br_op   = op;
        rs1     = a;
        rs2     = b;
        pc      = p;
        imm     = im;
        pred    = pr;
    endtask

    // Not-taken BEQ with correct prediction.
    task automatic present(input logic [5:0] t, input logic [31:0] p);
        drive(t, 1'b0, 1'b0, 3'b000, 32'd0, 32'd1, p, 32'h40, p + 32'd4);
    endtask

    task automatic idle();
        is_vld = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        out_rdy = 1'b1;
        idle();
        drive(6'd0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        idle();
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("reset_exfin", exfin, 0);
        chk("reset_exec", exec_cnt, 0);
        chk("reset_miss", miss_cnt, 0);
        chk("reset_acc", acc, 1);
        chk("reset_prsuc", prsuc, 0);
        chk("reset_prmiss", prmiss, 0);

        // BEQ taken, correctly predicted; two-cycle latency.
        drive(6'd1, 1'b0, 1'b0, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 32'h120);
        tick();
        idle();
        chk("beq_lat_not_yet", exfin, 0);
        tick();
        chk("beq_exfin", exfin, 1);
        chk("beq_tag", exfin_tag, 1);
        chk("beq_addr", jmpaddr, 32'h120);
        chk("beq_cond", jmpcond, 1);
        chk("beq_prsuc", prsuc, 1);
        chk("beq_prmiss", prmiss, 0);
        chk("beq_jj", jal_jalr, 0);
        tick();
        chk("beq_exec", exec_cnt, 1);
        chk("beq_miss", miss_cnt, 0);
        chk("beq_exfin_drop", exfin, 0);

        // BLT signed taken (mispredicted) then BLTU not-taken, back to back.
        drive(6'd2, 1'b0, 1'b0, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 32'h204);
        tick();
        drive(6'd3, 1'b0, 1'b0, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 32'h204);
        tick();
        idle();
        chk("blt_tag", exfin_tag, 2);
        chk("blt_addr", jmpaddr, 32'h240);
        chk("blt_cond", jmpcond, 1);
        chk("blt_prmiss", prmiss, 1);
        tick();
        chk("bltu_tag", exfin_tag, 3);
        chk("bltu_addr", jmpaddr, 32'h204);
        chk("bltu_cond", jmpcond, 0);
        chk("bltu_prsuc", prsuc, 1);
        chk("blt_miss_cnt", miss_cnt, 1);
        tick();
        chk("bltu_exec", exec_cnt, 3);
        chk("bltu_miss", miss_cnt, 1);

        // JALR clears bit 0; JAL target and link wrap around.
        drive(6'd4, 1'b0, 1'b1, 3'b000, 32'h1001, 32'd0, 32'h300, 32'h4, 32'h1004);
        tick();
        drive(6'd5, 1'b1, 1'b0, 3'b000, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'h8, 32'h4);
        tick();
        idle();
        chk("jalr_addr", jmpaddr, 32'h1004);
        chk("jalr_jj", jal_jalr, 1);
        chk("jalr_link", link, 32'h304);
        chk("jalr_cond", jmpcond, 1);
        tick();
        chk("jal_addr", jmpaddr, 32'h4);
        chk("jal_link", link, 32'h0);
        chk("jal_prsuc", prsuc, 1);

        // Undefined funct3 resolves not-taken even with equal operands.
        drive(6'd6, 1'b0, 1'b0, 3'b010, 32'd7, 32'd7, 32'h600, 32'h10, 32'h604);
        tick();
        idle();
        tick();
        chk("undef_addr", jmpaddr, 32'h604);
        chk("undef_cond", jmpcond, 0);
        tick();
        chk("undef_exec", exec_cnt, 6);

        // Backpressure: two entries held, third not accepted, then drain in order.
        out_rdy = 1'b0;
        present(6'd10, 32'h400);
        tick();
        present(6'd11, 32'h410);
        tick();
        present(6'd12, 32'h420);
        #1;
        chk("bp_acc_low", acc, 0);
        chk("bp_exfin", exfin, 1);
        chk("bp_tag0", exfin_tag, 10);
        tick();
        chk("bp_hold_tag", exfin_tag, 10);
        chk("bp_hold_addr", jmpaddr, 32'h404);
        chk("bp_hold_exfin", exfin, 1);
        chk("bp_hold_exec", exec_cnt, 6);
        chk("bp_hold_acc", acc, 0);
        out_rdy = 1'b1;
        #1;
        chk("bp_acc_rdy", acc, 1);
        tick();
        present(6'd13, 32'h430);
        chk("bp_ret_11", exfin_tag, 11);
        chk("bp_ret_11_addr", jmpaddr, 32'h414);
        tick();
        idle();
        chk("bp_ret_12", exfin_tag, 12);
        tick();
        chk("bp_ret_13", exfin_tag, 13);
        chk("bp_ret_13_v", exfin, 1);
        tick();
        chk("bp_drained", exfin, 0);
        chk("bp_exec", exec_cnt, 10);

        // Flush with two in flight and one presented.
        out_rdy = 1'b0;
        present(6'd20, 32'h500);
        tick();
        present(6'd21, 32'h510);
        tick();
        present(6'd22, 32'h520);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        out_rdy = 1'b1;
        chk("flush_exfin", exfin, 0);
        chk("flush_acc", acc, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flush_nothing", exfin, 0);
        end
        chk("flush_exec", exec_cnt, 10);
        chk("flush_miss", miss_cnt, 1);

        // Reset while stalled.
        out_rdy = 1'b0;
        present(6'd30, 32'h600);
        tick();
        present(6'd31, 32'h610);
        tick();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("mrst_exfin", exfin, 0);
        chk("mrst_exec", exec_cnt, 0);
        chk("mrst_miss", miss_cnt, 0);
        chk("mrst_acc", acc, 1);

        // Five mispredicted handshakes: 2-bit counters saturate at 3.
        out_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(6'(40 + i), 1'b0, 1'b0, 3'b000, 32'd9, 32'd9, 32'h700, 32'h10, 32'h704);
            tick();
        end
        idle();
        tick();
        tick();
        tick();
        chk("sat_miss2", miss_cnt2, 3);
        chk("sat_exec2", exec_cnt2, 3);
        chk("sat_miss", miss_cnt, 5);
        chk("sat_exec", exec_cnt, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
